// File: rtl/keypad_input_fifo_if.sv
// Keypad FIFO consumer-side bundle: raw key input, pop/clear controls,
// and the head/status outputs.
interface keypad_input_fifo_if #(
    parameter int W     = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  KEY_IN;
    logic          KEY_POP;
    logic          CLR_OVF;
    logic [W-1:0]  KEY_CODE;
    logic          KEY_VALID;
    logic          KEY_EVENT;
    logic [CW-1:0] COUNT;
    logic          OVF;

    modport master (
        output KEY_IN,
        output KEY_POP,
        output CLR_OVF,
        input  KEY_CODE,
        input  KEY_VALID,
        input  KEY_EVENT,
        input  COUNT,
        input  OVF
    );

    modport slave (
        input  KEY_IN,
        input  KEY_POP,
        input  CLR_OVF,
        output KEY_CODE,
        output KEY_VALID,
        output KEY_EVENT,
        output COUNT,
        output OVF
    );
endinterface

// File: rtl/keypad_input_fifo.sv
// Debounced keypad front end: one FIFO push per stable press,
// sticky overflow when a press arrives with the FIFO full.
module keypad_input_fifo #(
    parameter int W      = 8,
    parameter int DEPTH  = 4,
    parameter int DB_CYC = 3
) (
    input logic                CK,
    input logic                RST_N,
    keypad_input_fifo_if.slave kp
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = (DB_CYC > 1) ? $clog2(DB_CYC + 1) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DB_CYC - 1);
    localparam logic [DW-1:0] DB_ONE  = DW'(1);
    localparam bit DB1 = (DB_CYC == 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REL_WAIT
    } st_e;

    st_e         st_q;
    logic [DW-1:0] db_q;
    logic [W-1:0]  code_q;

    logic key_nz;
    logic key_same;
    logic db_done;
    logic accept;

    assign key_nz   = |kp.KEY_IN;
    assign key_same = (kp.KEY_IN == code_q);
    assign db_done  = (db_q == DB_LAST);

    // A press is accepted on the edge whose sample completes DB_CYC matches.
    assign accept = ((st_q == IDLE) && key_nz && DB1)
                 || ((st_q == PRESS_WAIT) && key_same && db_done);

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            st_q   <= IDLE;
            db_q   <= '0;
            code_q <= '0;
        end else begin
            unique case (st_q)
                IDLE: begin
                    if (key_nz) begin
                        code_q <= kp.KEY_IN;
                        db_q   <= DB_ONE;
                        st_q   <= DB1 ? HELD : PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (!key_nz) begin
                        db_q <= '0;
                        st_q <= IDLE;
                    end else if (!key_same) begin
                        code_q <= kp.KEY_IN;
                        db_q   <= DB_ONE;
                    end else if (db_done) begin
                        st_q <= HELD;
                    end else begin
                        db_q <= db_q + DB_ONE;
                    end
                end
                HELD: begin
                    if (!key_nz) begin
                        db_q <= DB_ONE;
                        st_q <= DB1 ? IDLE : REL_WAIT;
                    end
                end
                REL_WAIT: begin
                    // Any nonzero sample during release is bounce.
                    if (key_nz) begin
                        st_q <= HELD;
                    end else if (db_done) begin
                        db_q <= '0;
                        st_q <= IDLE;
                    end else begin
                        db_q <= db_q + DB_ONE;
                    end
                end
                default: begin
                    st_q <= IDLE;
                end
            endcase
        end
    end

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q;
    logic [AW-1:0] rp_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          ovf_q;
    logic          ovf_d;
    logic          evt_q;

    logic full;
    logic empty;
    logic pop_ok;
    logic push_ok;
    logic ovf_set;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign pop_ok  = kp.KEY_POP && !empty;
    // A simultaneous pop frees the slot a full FIFO needs for the push.
    assign push_ok = accept && (!full || pop_ok);
    assign ovf_set = accept && full && !pop_ok;

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    assign ovf_d = ovf_set || (ovf_q && !kp.CLR_OVF);

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            evt_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wp_q <= wp_q + AW'(1);
            end
            if (pop_ok) begin
                rp_q <= rp_q + AW'(1);
            end
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            evt_q <= accept;
        end
    end

    always_ff @(posedge CK) begin
        if (push_ok) begin
            mem_q[wp_q] <= kp.KEY_IN;
        end
    end

    assign kp.KEY_CODE  = empty ? '0 : mem_q[rp_q];
    assign kp.KEY_VALID = !empty;
    assign kp.KEY_EVENT = evt_q;
    assign kp.COUNT     = cnt_q;
    assign kp.OVF       = ovf_q;
endmodule

// File: doc/keypad_input_fifo.md
KEYPAD_INPUT_FIFO -- requirements
Module: keypad_input_fifo

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter W, default 8, SHALL set the key code width.
REQ-003 Parameter DEPTH, default 4, power of two and at least 2, SHALL set the FIFO entry count.
REQ-004 Parameter DB_CYC, default 3, at least 1, SHALL set the debounce length in clock cycles.
REQ-005 Port CK, input, 1 bit, SHALL be the clock; all state updates on its rising edge.
REQ-006 Port RST_N, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-007 Port KEY_IN, input, W bits, SHALL be the raw keypad code; 0 means no key, nonzero means that key is pressed.
REQ-008 Port KEY_POP, input, 1 bit, SHALL be the consumer request to remove the head entry.
REQ-009 Port CLR_OVF, input, 1 bit, SHALL clear the overflow flag.
REQ-010 Port KEY_CODE, output, W bits, SHALL be the head FIFO entry, or 0 when empty.
REQ-011 Port KEY_VALID, output, 1 bit, SHALL be 1 when the FIFO is not empty.
REQ-012 Port KEY_EVENT, output, 1 bit, SHALL be a one-cycle pulse marking an accepted press.
REQ-013 Port COUNT, output, clog2(DEPTH+1) bits, SHALL be the current entry count.
REQ-014 Port OVF, output, 1 bit, SHALL be the sticky overflow flag.

Function
REQ-015 The debounce FSM SHALL have four states: IDLE, PRESS_WAIT, HELD, REL_WAIT, plus a stability counter and a captured code.
REQ-016 In IDLE, an edge sampling nonzero KEY_IN SHALL capture the code, set the counter to 1, and go to PRESS_WAIT; with DB_CYC=1 it SHALL accept immediately.
REQ-017 In PRESS_WAIT, KEY_IN equal to the captured code SHALL increment the counter; on reaching DB_CYC the press SHALL be accepted and the state SHALL go to HELD.
REQ-018 In PRESS_WAIT, a different nonzero code SHALL recapture and set the counter to 1; KEY_IN=0 SHALL return to IDLE with no push.
REQ-019 On acceptance, on that same edge, the code SHALL be pushed and KEY_EVENT SHALL be 1 for exactly the following cycle.
REQ-020 After acceptance, KEY_VALID, KEY_CODE, and COUNT SHALL reflect the push in the cycle following that edge.
REQ-021 In HELD, any nonzero KEY_IN, same or different, SHALL be ignored; KEY_IN=0 SHALL go to REL_WAIT with the counter at 1.
REQ-022 In REL_WAIT, nonzero KEY_IN SHALL return to HELD with no push, since it is bounce; DB_CYC consecutive zero samples SHALL return to IDLE.
REQ-023 Each accepted press SHALL push exactly one entry regardless of hold duration.
REQ-024 The FIFO SHALL be first-in first-out, with read and write pointers wrapping modulo DEPTH.
REQ-025 KEY_POP with KEY_VALID=1 SHALL remove the head at the edge; KEY_POP when empty SHALL be ignored.
REQ-026 A push when full without a pop on the same edge SHALL drop the new code, leave the FIFO unchanged, and set OVF.
REQ-027 A push and a pop on the same edge SHALL both take effect, with COUNT unchanged; if the FIFO was full, OVF SHALL NOT be set.
REQ-028 A push and a pop on the same edge with the FIFO empty SHALL perform the push only, since the pop is ignored.
REQ-029 OVF SHALL remain set until CLR_OVF; CLR_OVF and a new overflow on the same edge SHALL leave OVF=1.
REQ-030 All outputs SHALL be registered, or decoded only from registered state.

Reset
REQ-031 RST_N=0 SHALL immediately force the FSM to IDLE, the counter, pointers, and COUNT to 0, OVF=0, KEY_EVENT=0, KEY_VALID=0, and KEY_CODE=0.
REQ-032 Reset asserted mid-PRESS_WAIT or mid-HELD SHALL discard the press; a key still held at release of reset SHALL be debounced from scratch.
REQ-033 FIFO storage contents need not be cleared; KEY_CODE SHALL read 0 while empty.

Verification
Use DB_CYC=3, DEPTH=4, W=8 unless noted.
REQ-034 KEY_IN=12 held for 5 cycles, then 0: one KEY_EVENT pulse after the 3rd sampling edge, KEY_CODE=12, COUNT=1.
REQ-035 KEY_IN sequence 12,0,12,12,12: acceptance only after the final three 12s, with exactly one push.
REQ-036 KEY_IN=4 held for 20 cycles with mid-hold glitches to 0 for 1 cycle, then 0 for 3 cycles: one push only, FSM returns to IDLE.
REQ-037 Press 1,2,3,4,5 in turn with no pops: COUNT=4 and OVF=1; popping yields 1,2,3,4, then KEY_VALID=0 and KEY_CODE=0.
REQ-038 FIFO full, KEY_POP coinciding with acceptance of code 9: COUNT stays 4, OVF=0, and 9 is the last entry.
REQ-039 COUNT=2 and KEY_IN=7 in PRESS_WAIT, RST_N pulsed low: all outputs 0 immediately; after release with 7 still held, a push occurs 3 edges later.
